// File: rtl/bin2bcd_serial_if.sv
// Start/done handshake bundle for bin2bcd_serial.
// The controller drives the request side; the converter drives the result side.
interface bin2bcd_serial_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  i_start;
  logic [BIN_W-1:0]      i_bin;
  logic                  o_busy;
  logic                  o_done;
  logic [4*DIGITS-1:0]   o_bcd;
  logic                  o_ovf;
  logic                  o_sign;

  modport master (
    output i_start, i_bin,
    input  o_busy, o_done, o_bcd, o_ovf, o_sign
  );

  modport slave (
    input  i_start, i_bin,
    output o_busy, o_done, o_bcd, o_ovf, o_sign
  );
endinterface

// File: rtl/bin2bcd_serial.sv
// Iterative double-dabble binary-to-BCD converter: one input bit per clock.
// Define BIN2BCD_SIGNED_EN to treat i_bin as two's complement and report the sign on o_sign.
module bin2bcd_serial #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  bin2bcd_serial_if.slave     bus
);
  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_r;
  logic [BIN_W-1:0]   sreg_r;
  logic [ACC_W-1:0]   acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               ovf_r;
  logic               done_r;
  logic [ACC_W-1:0]   bcd_r;
  logic               ovf_out_r;

  logic [ACC_W-1:0]   adj_s;
  logic [ACC_W-1:0]   acc_shift_s;
  logic               ovf_next_s;
  logic [BIN_W-1:0]   load_s;

  // Digit adjust: each 4-bit digit >= 5 gets +3, with no carry into the next digit.
  function automatic logic [ACC_W-1:0] dabble_adjust(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] res;
    res = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        res[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end else begin
        res[4*d +: 4] = acc[4*d +: 4];
      end
    end
    return res;
  endfunction

  // Next accumulator value and overflow for one shift step.
  always_comb begin
    adj_s       = dabble_adjust(acc_r);
    acc_shift_s = {adj_s[ACC_W-2:0], sreg_r[BIN_W-1]};
    ovf_next_s  = ovf_r | adj_s[ACC_W-1];
  end

`ifdef BIN2BCD_SIGNED_EN
  logic sign_r;
  logic sign_out_r;

  // Magnitude of the two's-complement input; the most negative value maps to 2^(BIN_W-1).
  always_comb begin
    if (bus.i_bin[BIN_W-1]) begin
      load_s = (~bus.i_bin) + {{(BIN_W-1){1'b0}}, 1'b1};
    end else begin
      load_s = bus.i_bin;
    end
  end

  // Sign latched on acceptance and published together with the BCD result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sign_r     <= 1'b0;
      sign_out_r <= 1'b0;
    end else begin
      if (state_r == ST_IDLE && bus.i_start) begin
        sign_r <= bus.i_bin[BIN_W-1];
      end
      if (state_r == ST_SHIFT && cnt_r == '0) begin
        sign_out_r <= sign_r;
      end
    end
  end

  assign bus.o_sign = sign_out_r;
`else
  // Unsigned build loads the input unchanged.
  always_comb begin
    load_s = bus.i_bin;
  end

  assign bus.o_sign = 1'b0;
`endif

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      sreg_r    <= '0;
      acc_r     <= '0;
      cnt_r     <= '0;
      ovf_r     <= 1'b0;
      done_r    <= 1'b0;
      bcd_r     <= '0;
      ovf_out_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.i_start) begin
            sreg_r  <= load_s;
            acc_r   <= '0;
            ovf_r   <= 1'b0;
            cnt_r   <= CNT_W'(BIN_W - 1);
            state_r <= ST_SHIFT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          acc_r  <= acc_shift_s;
          sreg_r <= {sreg_r[BIN_W-2:0], 1'b0};
          ovf_r  <= ovf_next_s;
          if (cnt_r == '0) begin
            bcd_r     <= acc_shift_s;
            ovf_out_r <= ovf_next_s;
            done_r    <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy = (state_r == ST_SHIFT) || (state_r == ST_DONE);
  assign bus.o_done = done_r;
  assign bus.o_bcd  = bcd_r;
  assign bus.o_ovf  = ovf_out_r;
endmodule

// File: tb/tb_bin2bcd_serial.sv
// Directed bench for bin2bcd_serial: a 16-bit/5-digit instance and a 16-bit/4-digit instance
// for overflow; expected values are hand-computed decimal conversions.
module tb_bin2bcd_serial;
  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;

  bin2bcd_serial_if #(.BIN_W(16), .DIGITS(5)) bus5 ();
  bin2bcd_serial_if #(.BIN_W(16), .DIGITS(4)) bus4 ();

  bin2bcd_serial #(.BIN_W(16), .DIGITS(5)) u_dut5 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus5));
  bin2bcd_serial #(.BIN_W(16), .DIGITS(4)) u_dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one conversion; lat counts cycles with cycle 1 beginning at the accepting edge.
  task automatic convert(input bit sel4, input logic [15:0] val, output logic [19:0] bcd,
                         output logic ovf, output logic sgn, output int lat,
                         output logic busy1, output logic done_after);
    @(negedge clk);
    if (sel4) begin bus4.i_bin = val; bus4.i_start = 1'b1; end
    else      begin bus5.i_bin = val; bus5.i_start = 1'b1; end
    @(posedge clk); #1;
    bus4.i_start = 1'b0;
    bus5.i_start = 1'b0;
    busy1 = sel4 ? bus4.o_busy : bus5.o_busy;
    lat = 1;
    while (!(sel4 ? bus4.o_done : bus5.o_done) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    bcd = sel4 ? {4'h0, bus4.o_bcd} : bus5.o_bcd;
    ovf = sel4 ? bus4.o_ovf : bus5.o_ovf;
    sgn = sel4 ? bus4.o_sign : bus5.o_sign;
    @(posedge clk); #1;
    done_after = sel4 ? bus4.o_done : bus5.o_done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus5.i_start = 1'b0; bus5.i_bin = 16'd0;
    bus4.i_start = 1'b0; bus4.i_bin = 16'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vectors++; if (bus5.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus5.o_busy); end
    vectors++; if (bus5.o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus5.o_done); end
    vectors++; if (bus5.o_bcd !== 20'h00000) begin errors++; $display("FAIL reset_bcd: got %h expected 00000", bus5.o_bcd); end
    vectors++; if (bus5.o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus5.o_ovf); end
    vectors++; if (bus5.o_sign !== 1'b0) begin errors++; $display("FAIL reset_sign: got %b expected 0", bus5.o_sign); end
  endtask

  task automatic test_convert();
    logic [15:0] vin [5];
    logic [19:0] vexp [5];
    logic        sexp [5];
    logic [19:0] bcd;
    logic        ovf, sgn, busy1, done_after;
    int          lat;
    vin[0] = 16'd12345; vexp[0] = 20'h12345; sexp[0] = 1'b0;
    vin[2] = 16'h0000;  vexp[2] = 20'h00000; sexp[2] = 1'b0;
    vin[4] = 16'h7FFF;  vexp[4] = 20'h32767; sexp[4] = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    vin[1] = 16'hFFFF;  vexp[1] = 20'h00001; sexp[1] = 1'b1;
    vin[3] = 16'h8000;  vexp[3] = 20'h32768; sexp[3] = 1'b1;
`else
    vin[1] = 16'hFFFF;  vexp[1] = 20'h65535; sexp[1] = 1'b0;
    vin[3] = 16'h8000;  vexp[3] = 20'h32768; sexp[3] = 1'b0;
`endif
    for (int i = 0; i < 5; i++) begin
      convert(1'b0, vin[i], bcd, ovf, sgn, lat, busy1, done_after);
      vectors++; if (bcd !== vexp[i]) begin errors++; $display("FAIL conv_bcd[%0d]: got %h expected %h", i, bcd, vexp[i]); end
      vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL conv_ovf[%0d]: got %b expected 0", i, ovf); end
      vectors++; if (sgn !== sexp[i]) begin errors++; $display("FAIL conv_sign[%0d]: got %b expected %b", i, sgn, sexp[i]); end
      vectors++; if (lat !== 17) begin errors++; $display("FAIL conv_latency[%0d]: got %0d expected 17", i, lat); end
      vectors++; if (busy1 !== 1'b1) begin errors++; $display("FAIL conv_busy[%0d]: got %b expected 1", i, busy1); end
      vectors++; if (done_after !== 1'b0) begin errors++; $display("FAIL conv_done_width[%0d]: got %b expected 0", i, done_after); end
    end
  endtask

  task automatic test_overflow();
    logic [19:0] bcd;
    logic        ovf, sgn, busy1, done_after;
    int          lat;
    convert(1'b1, 16'd10000, bcd, ovf, sgn, lat, busy1, done_after);
    vectors++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf10000_flag: got %b expected 1", ovf); end
    vectors++; if (bcd[15:0] !== 16'h0000) begin errors++; $display("FAIL ovf10000_bcd: got %h expected 0000", bcd[15:0]); end
    convert(1'b1, 16'd9999, bcd, ovf, sgn, lat, busy1, done_after);
    vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf9999_flag: got %b expected 0", ovf); end
    vectors++; if (bcd[15:0] !== 16'h9999) begin errors++; $display("FAIL ovf9999_bcd: got %h expected 9999", bcd[15:0]); end
    vectors++; if (lat !== 17) begin errors++; $display("FAIL ovf9999_latency: got %0d expected 17", lat); end
  endtask

  task automatic test_ignore_start();
    int cyc;
    @(negedge clk);
    bus5.i_bin = 16'd12345; bus5.i_start = 1'b1;
    @(posedge clk); #1;
    bus5.i_start = 1'b0;
    cyc = 1;
    while (!bus5.o_done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5) begin bus5.i_bin = 16'd999; bus5.i_start = 1'b1; end
      if (cyc == 6) bus5.i_start = 1'b0;
    end
    vectors++; if (bus5.o_bcd !== 20'h12345) begin errors++; $display("FAIL ignore_bcd: got %h expected 12345", bus5.o_bcd); end
    vectors++; if (cyc !== 17) begin errors++; $display("FAIL ignore_latency: got %0d expected 17", cyc); end
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus5.o_busy !== 1'b0) begin errors++; $display("FAIL ignore_no_queue: got busy %b expected 0", bus5.o_busy); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    bus5.i_bin = 16'd4321; bus5.i_start = 1'b1;
    @(posedge clk); #1;
    bus5.i_bin = 16'd1234;
    cyc = 1;
    while (!bus5.o_done && cyc < 100) begin @(posedge clk); #1; cyc++; end
    vectors++; if (bus5.o_bcd !== 20'h04321) begin errors++; $display("FAIL b2b_first_bcd: got %h expected 04321", bus5.o_bcd); end
    vectors++; if (cyc !== 17) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 17", cyc); end
    @(posedge clk); #1;
    vectors++; if (bus5.o_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy %b expected 0", bus5.o_busy); end
    @(posedge clk); #1;
    bus5.i_start = 1'b0;
    vectors++; if (bus5.o_busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got busy %b expected 1", bus5.o_busy); end
    cyc = 2;
    while (!bus5.o_done && cyc < 100) begin @(posedge clk); #1; cyc++; end
    vectors++; if (cyc !== 18) begin errors++; $display("FAIL b2b_interval: got %0d expected 18", cyc); end
    vectors++; if (bus5.o_bcd !== 20'h01234) begin errors++; $display("FAIL b2b_second_bcd: got %h expected 01234", bus5.o_bcd); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [19:0] bcd;
    logic        ovf, sgn, busy1, done_after, seen;
    int          lat;
    @(negedge clk);
    bus5.i_bin = 16'd54321; bus5.i_start = 1'b1;
    @(posedge clk); #1;
    bus5.i_start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus5.o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus5.o_busy); end
    vectors++; if (bus5.o_bcd !== 20'h00000) begin errors++; $display("FAIL abort_bcd: got %h expected 00000", bus5.o_bcd); end
    vectors++; if (bus5.o_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", bus5.o_done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus5.o_done) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", seen); end
    convert(1'b0, 16'd777, bcd, ovf, sgn, lat, busy1, done_after);
    vectors++; if (bcd !== 20'h00777) begin errors++; $display("FAIL abort_recover_bcd: got %h expected 00777", bcd); end
    vectors++; if (lat !== 17) begin errors++; $display("FAIL abort_recover_latency: got %0d expected 17", lat); end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_convert();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
